// File: rtl/obi_dbg_pkg.sv
// Shared types and helpers for the debug-module OBI plumbing.
package obi_dbg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain
  } bridge_state_e;

  // OBI handshake parity is the inverted signal.
  function automatic logic obi_par(input logic x);
    return ~x;
  endfunction

endpackage

// File: rtl/obi_sba_timeout.sv
// Response watchdog: counts enabled cycles and pulses expire when the budget runs out.
module obi_sba_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk_i, rst_i, en_i};
    assign expire_o  = 1'b0;
  end else begin : g_on
    localparam logic [TW-1:0] Last = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          expire;

    // Expiry fires on the edge where the timer would reach TIMEOUT_CYCLES.
    always_comb begin
      expire  = en_i && (timer_q == Last);
      timer_d = (!en_i || expire) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_d;
      end
    end

    assign expire_o = expire;
  end

endmodule

// File: rtl/obi_sba_bridge.sv
// In-order OBI forwarder for the debug SBA port with depth limit, parity check and
// response timeout; timed-out transactions get a synthesised error and their late
// responses are drained.
module obi_sba_bridge
  import obi_dbg_pkg::*;
#(
  parameter int unsigned OBI_AW          = 32,
  parameter int unsigned OBI_DW          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1023,
  parameter int unsigned PARITY_CHECK    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                target_req_i,
  input  logic                target_we_i,
  input  logic [OBI_AW-1:0]   target_addr_i,
  input  logic [OBI_DW/8-1:0] target_be_i,
  input  logic [OBI_DW-1:0]   target_wdata_i,
  output logic                target_gnt_o,
  output logic                target_rvalid_o,
  output logic                target_err_o,
  output logic [OBI_DW-1:0]   target_rdata_o,
  output logic                initiator_req_o,
  output logic                initiator_reqpar_o,
  output logic [OBI_AW-1:0]   initiator_addr_o,
  output logic                initiator_we_o,
  output logic [OBI_DW/8-1:0] initiator_be_o,
  output logic [OBI_DW-1:0]   initiator_wdata_o,
  input  logic                initiator_gnt_i,
  input  logic                initiator_gntpar_i,
  input  logic                initiator_rvalid_i,
  input  logic                initiator_rvalidpar_i,
  input  logic                initiator_err_i,
  input  logic [OBI_DW-1:0]   initiator_rdata_i,
  input  logic                clear_i,
  output logic                timeout_o,
  output logic                parity_err_o,
  output logic                busy_o
);

  localparam int unsigned    CW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0]    MaxOut = MAX_OUTSTANDING[CW:0];

  bridge_state_e state_q, state_d;
  logic [CW-1:0] o_cnt_q, o_cnt_d, d_cnt_q, d_cnt_d;
  logic          synth_q, timeout_q, timeout_d, par_err_q, par_err_d;
  logic [CW:0]   inflight;
  logic          can_issue, accept, fwd, drain_rsp, timer_en, expire, par_bad;

  assign inflight  = {1'b0, o_cnt_q} + {1'b0, d_cnt_q};
  assign can_issue = (state_q != StDrain) && (inflight < MaxOut);
  assign accept    = target_req_i & target_gnt_o;
  // Responses owed to timed-out transactions are the oldest, so they are eaten first.
  assign drain_rsp = initiator_rvalid_i & (d_cnt_q != '0);
  assign fwd       = initiator_rvalid_i & (d_cnt_q == '0);
  assign timer_en  = (o_cnt_q != '0) & ~fwd;

  obi_sba_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (timer_en),
    .expire_o(expire)
  );

  assign par_bad = (PARITY_CHECK != 0) &&
                   ((initiator_gntpar_i != obi_par(initiator_gnt_i)) ||
                    (initiator_rvalidpar_i != obi_par(initiator_rvalid_i)));

  always_comb begin
    o_cnt_d = o_cnt_q;
    d_cnt_d = d_cnt_q;
    if (accept) o_cnt_d = o_cnt_d + CW'(1);
    // Guard against stray responses after a mid-operation reset.
    if (fwd && (o_cnt_q != '0)) o_cnt_d = o_cnt_d - CW'(1);
    if (expire) begin
      o_cnt_d = o_cnt_d - CW'(1);
      d_cnt_d = d_cnt_d + CW'(1);
    end
    if (drain_rsp) d_cnt_d = d_cnt_d - CW'(1);

    timeout_d = (timeout_q & ~clear_i) | expire;
    par_err_d = (par_err_q & ~clear_i) | par_bad;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy: begin
        if (expire) state_d = StDrain;
        else if ((o_cnt_d == '0) && (d_cnt_d == '0)) state_d = StIdle;
      end
      StDrain: if (d_cnt_d == '0) state_d = (o_cnt_d == '0) ? StIdle : StBusy;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      o_cnt_q   <= '0;
      d_cnt_q   <= '0;
      synth_q   <= 1'b0;
      timeout_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_cnt_q   <= o_cnt_d;
      d_cnt_q   <= d_cnt_d;
      synth_q   <= expire;
      timeout_q <= timeout_d;
      par_err_q <= par_err_d;
    end
  end

  assign initiator_req_o    = target_req_i & can_issue;
  assign initiator_reqpar_o = obi_par(initiator_req_o);
  assign initiator_addr_o   = target_addr_i;
  assign initiator_we_o     = target_we_i;
  assign initiator_be_o     = target_be_i;
  assign initiator_wdata_o  = target_wdata_i;
  assign target_gnt_o       = initiator_gnt_i & can_issue;

  // synth_q implies d_cnt > 0, so it never overlaps a forwarded response.
  assign target_rvalid_o = synth_q | fwd;
  assign target_err_o    = synth_q | (fwd & initiator_err_i);
  assign target_rdata_o  = fwd ? initiator_rdata_i : '0;

  assign timeout_o    = timeout_q;
  assign parity_err_o = par_err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_obi_sba_bridge.sv
// Directed bench for obi_sba_bridge (MAX_OUTSTANDING=2, TIMEOUT_CYCLES=8).
module tb_obi_sba_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic        i_req, i_reqpar, i_we;
  logic [31:0] i_addr, i_wdata;
  logic [3:0]  i_be;
  logic        gnt = 1'b0, bad_gntpar = 1'b0, rvalid = 1'b0, rerr = 1'b0;
  logic [31:0] rdata = '0;
  logic        gntpar, rvalidpar;
  logic        clear = 1'b0;
  logic        timeout, parity_err, busy;

  int checks = 0;
  int failures = 0;

  assign gntpar    = ~gnt ^ bad_gntpar;
  assign rvalidpar = ~rvalid;

  always #5 clk = ~clk;

  obi_sba_bridge #(
    .OBI_AW         (32),
    .OBI_DW         (32),
    .MAX_OUTSTANDING(2),
    .TIMEOUT_CYCLES (8),
    .PARITY_CHECK   (1)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .target_req_i         (req),
    .target_we_i          (we),
    .target_addr_i        (addr),
    .target_be_i          (be),
    .target_wdata_i       (wdata),
    .target_gnt_o         (gnt_o),
    .target_rvalid_o      (rvalid_o),
    .target_err_o         (err_o),
    .target_rdata_o       (rdata_o),
    .initiator_req_o      (i_req),
    .initiator_reqpar_o   (i_reqpar),
    .initiator_addr_o     (i_addr),
    .initiator_we_o       (i_we),
    .initiator_be_o       (i_be),
    .initiator_wdata_o    (i_wdata),
    .initiator_gnt_i      (gnt),
    .initiator_gntpar_i   (gntpar),
    .initiator_rvalid_i   (rvalid),
    .initiator_rvalidpar_i(rvalidpar),
    .initiator_err_i      (rerr),
    .initiator_rdata_i    (rdata),
    .clear_i              (clear),
    .timeout_o            (timeout),
    .parity_err_o         (parity_err),
    .busy_o               (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_ireq", i_req, 0);
    chk("rst_reqpar", i_reqpar, 1);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_parity", parity_err, 0);

    // Single read, response three cycles after accept
    req = 1'b1; addr = 32'h0000_1000; be = 4'hf; gnt = 1'b1;
    #1;
    chk("rd_ireq", i_req, 1);
    chk("rd_reqpar", i_reqpar, 0);
    chk("rd_gnt", gnt_o, 1);
    chk("rd_addr", i_addr, 32'h0000_1000);
    tick();
    req = 1'b0; gnt = 1'b0;
    #1;
    chk("rd_busy", busy, 1);
    tick();
    tick();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_rvalid", rvalid_o, 1);
    chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("rd_err", err_o, 0);
    tick();
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("rd_idle", busy, 0);
    chk("rd_rvalid_low", rvalid_o, 0);

    // Depth limit of two outstanding
    req = 1'b1; gnt = 1'b1;
    #1;
    chk("dep_gnt1", gnt_o, 1);
    tick();
    chk("dep_gnt2", gnt_o, 1);
    tick();
    chk("dep_gnt3_blocked", gnt_o, 0);
    chk("dep_ireq_blocked", i_req, 0);
    tick();
    rvalid = 1'b1; rdata = 32'h1;
    #1;
    chk("dep_gnt_rsp_cycle", gnt_o, 0);
    chk("dep_rsp1", rvalid_o, 1);
    tick();
    rvalid = 1'b0;
    #1;
    chk("dep_gnt3_freed", gnt_o, 1);
    tick();
    req = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2;
    #1;
    chk("dep_rsp2", rdata_o, 32'h2);
    tick();
    rdata = 32'h3;
    #1;
    chk("dep_rsp3", rdata_o, 32'h3);
    tick();
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("dep_idle", busy, 0);

    // Timeout and drain: slave silent, late response at accept+20
    req = 1'b1; gnt = 1'b1;
    tick();
    req = 1'b0; gnt = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("to_quiet", rvalid_o, 0);
      tick();
    end
    #1;
    chk("to_rvalid", rvalid_o, 1);
    chk("to_err", err_o, 1);
    chk("to_rdata", rdata_o, 0);
    chk("to_flag", timeout, 1);
    chk("to_busy", busy, 1);
    req = 1'b1; gnt = 1'b1;
    #1;
    chk("to_blocked", gnt_o, 0);
    tick();
    for (int i = 10; i < 20; i++) begin
      #1;
      chk("to_drain_gnt", gnt_o, 0);
      chk("to_drain_rvalid", rvalid_o, 0);
      tick();
    end
    rvalid = 1'b1; rdata = 32'h1234_5678;
    #1;
    chk("to_late_dropped", rvalid_o, 0);
    chk("to_late_gnt", gnt_o, 0);
    tick();
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("to_unblocked", gnt_o, 1);
    chk("to_idle", busy, 0);
    req = 1'b0; gnt = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("to_cleared", timeout, 0);

    // Genuine response in the expiry cycle wins
    req = 1'b1; gnt = 1'b1;
    tick();
    req = 1'b0; gnt = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      #1;
      chk("race_quiet", rvalid_o, 0);
      tick();
    end
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    #1;
    chk("race_rvalid", rvalid_o, 1);
    chk("race_err", err_o, 0);
    chk("race_rdata", rdata_o, 32'hCAFE_F00D);
    tick();
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("race_no_synth", rvalid_o, 0);
    chk("race_no_timeout", timeout, 0);
    chk("race_idle", busy, 0);

    // Grant parity error, traffic unaffected, clear vs. set
    req = 1'b1; gnt = 1'b1; bad_gntpar = 1'b1;
    #1;
    chk("par_gnt", gnt_o, 1);
    chk("par_pre", parity_err, 0);
    tick();
    req = 1'b0; gnt = 1'b0; bad_gntpar = 1'b0;
    #1;
    chk("par_set", parity_err, 1);
    rvalid = 1'b1; rdata = 32'h55;
    #1;
    chk("par_rsp", rdata_o, 32'h55);
    chk("par_rsp_err", err_o, 0);
    tick();
    rvalid = 1'b0; rdata = '0;
    #1;
    chk("par_idle", busy, 0);
    clear = 1'b1; gnt = 1'b1; bad_gntpar = 1'b1;
    tick();
    gnt = 1'b0; bad_gntpar = 1'b0;
    #1;
    chk("par_set_wins", parity_err, 1);
    tick();
    clear = 1'b0;
    #1;
    chk("par_cleared", parity_err, 0);

    // Reset with one transaction outstanding
    req = 1'b1; gnt = 1'b1;
    tick();
    req = 1'b0; gnt = 1'b0;
    #1;
    chk("mr_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rvalid", rvalid_o, 0);
    chk("mr_err", err_o, 0);
    chk("mr_gnt", gnt_o, 0);
    chk("mr_ireq", i_req, 0);
    chk("mr_reqpar", i_reqpar, 1);
    chk("mr_timeout", timeout, 0);
    chk("mr_parity", parity_err, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("mr_no_synth", rvalid_o, 0);
      tick();
    end
    rvalid = 1'b1; rerr = 1'b1; rdata = 32'h77;
    #1;
    chk("mr_stray_rvalid", rvalid_o, 1);
    chk("mr_stray_err", err_o, 1);
    chk("mr_stray_rdata", rdata_o, 32'h77);
    tick();
    rvalid = 1'b0; rerr = 1'b0; rdata = '0;
    #1;
    chk("mr_end_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
